// File: rtl/iir_pkg.sv
// Shared FSM state type, coefficient addresses and reset coefficients for the
// iir_seq sample/coefficient sequencer.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_A0 = 3'd0;
    localparam logic [2:0] ADDR_A1 = 3'd1;
    localparam logic [2:0] ADDR_B0 = 3'd2;
    localparam logic [2:0] ADDR_B1 = 3'd3;
    localparam logic [2:0] ADDR_B2 = 3'd4;

    localparam int NUM_COEF = 5;

    localparam int DEF_A0 = -8;
    localparam int DEF_A1 = -8;
    localparam int DEF_B0 = 8;
    localparam int DEF_B1 = 16;
    localparam int DEF_B2 = 8;

    // Reset value of coefficient slot idx (slot order matches the cfg_addr map).
    function automatic int coef_default(input int idx);
        int v;
        case (idx)
            0:       v = DEF_A0;
            1:       v = DEF_A1;
            2:       v = DEF_B0;
            3:       v = DEF_B1;
            default: v = DEF_B2;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/iir_vpipe.sv
// LAT-deep valid shift register mirroring the external filter latency; the
// tail marks the cycle a result is present and the empty flag gates draining.
module iir_vpipe #(
    parameter int LAT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    output logic o_tail,
    output logic o_empty
);

    logic [LAT-1:0] r_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_tail  = r_sr[LAT-1];
    assign o_empty = ~|r_sr;

endmodule

// File: rtl/iir_seq.sv
// Sample sequencer for an external IIR step engine: feeds samples, tracks
// results, and swaps shadow coefficients in only once the pipeline is empty.
module iir_seq
    import iir_pkg::*;
#(
    parameter int DW  = 8,
    parameter int LAT = 2,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          cfg_wr,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic [CW-1:0] sample_count,
    output logic [DW-1:0] iir_x,
    output logic          iir_enable,
    output logic          iir_clear,
    input  logic [DW-1:0] iir_z,
    output logic [DW-1:0] iir_a0,
    output logic [DW-1:0] iir_a1,
    output logic [DW-1:0] iir_b0,
    output logic [DW-1:0] iir_b1,
    output logic [DW-1:0] iir_b2
);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_clear;
    logic [CW-1:0]         r_count;
    logic signed [DW-1:0]  r_shadow [NUM_COEF];
    logic signed [DW-1:0]  r_active [NUM_COEF];

    logic [DW-1:0]         r_x_p0;
    logic                  r_vld_p0;
    logic [DW-1:0]         r_mdata;

    logic                  w_accept;
    logic                  w_tail;
    logic                  w_pipe_empty;

    assign s_ready  = (r_state == ST_RUN);
    assign w_accept = s_valid & s_ready;

    // Control: state, commit handshake, sample counter, coefficient banks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_clear <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < NUM_COEF; i++) begin
                r_shadow[i] <= DW'(coef_default(i));
                r_active[i] <= DW'(coef_default(i));
            end
        end else begin
            r_clear <= 1'b0;

            if (cfg_wr) begin
                case (cfg_addr)
                    ADDR_A0: r_shadow[0] <= cfg_data;
                    ADDR_A1: r_shadow[1] <= cfg_data;
                    ADDR_B0: r_shadow[2] <= cfg_data;
                    ADDR_B1: r_shadow[3] <= cfg_data;
                    ADDR_B2: r_shadow[4] <= cfg_data;
                    default: ;
                endcase
            end

            if (w_accept) begin
                r_count <= r_count + CW'(1);
            end

            case (r_state)
                ST_RUN: begin
                    if (cfg_commit) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Results issued before the commit must leave with the old coefficients.
                    if (!r_vld_p0 && w_pipe_empty) begin
                        r_state <= ST_LOAD;
                        r_clear <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < NUM_COEF; i++) begin
                        r_active[i] <= r_shadow[i];
                    end
                    r_count <= '0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0: registered sample and step strobe towards the filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_p0   <= '0;
            r_vld_p0 <= 1'b0;
            r_mdata  <= '0;
        end else begin
            r_vld_p0 <= w_accept;
            if (w_accept) begin
                r_x_p0 <= s_data;
            end
            if (w_tail) begin
                r_mdata <= iir_z;
            end
        end
    end

    iir_vpipe #(
        .LAT (LAT)
    ) u_vpipe (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_vld   (r_vld_p0),
        .o_tail  (w_tail),
        .o_empty (w_pipe_empty)
    );

    // The filter result is only valid in the tail cycle; hold the last one otherwise.
    assign m_valid      = w_tail;
    assign m_data       = w_tail ? iir_z : r_mdata;

    assign cfg_busy     = r_busy;
    assign sample_count = r_count;
    assign iir_x        = r_x_p0;
    assign iir_enable   = r_vld_p0;
    assign iir_clear    = r_clear;

    assign iir_a0       = r_active[0];
    assign iir_a1       = r_active[1];
    assign iir_b0       = r_active[2];
    assign iir_b1       = r_active[3];
    assign iir_b2       = r_active[4];

endmodule

// File: tb/tb_iir_seq.sv
// Directed bench for iir_seq: a stand-in filter returns x ^ 8'hA5 LAT clocks
// after each enable; a table drives the streaming test, sequences cover commits.
module tb_iir_seq;

    localparam int DW  = 8;
    localparam int LAT = 2;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          cfg_wr;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_busy;
    logic [CW-1:0] sample_count;
    logic [DW-1:0] iir_x;
    logic          iir_enable;
    logic          iir_clear;
    logic [DW-1:0] iir_z;
    logic [DW-1:0] iir_a0, iir_a1, iir_b0, iir_b1, iir_b2;

    always #5 clk = ~clk;

    iir_seq #(.DW(DW), .LAT(LAT), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .cfg_busy     (cfg_busy),
        .sample_count (sample_count),
        .iir_x        (iir_x),
        .iir_enable   (iir_enable),
        .iir_clear    (iir_clear),
        .iir_z        (iir_z),
        .iir_a0       (iir_a0),
        .iir_a1       (iir_a1),
        .iir_b0       (iir_b0),
        .iir_b1       (iir_b1),
        .iir_b2       (iir_b2)
    );

    // Stand-in filter with LAT = 2 clocks of latency.
    logic [DW-1:0] zd0 = '0;
    logic [DW-1:0] zd1 = '0;
    always @(posedge clk) begin
        zd0 <= iir_enable ? (iir_x ^ 8'hA5) : 8'h00;
        zd1 <= zd0;
    end
    assign iir_z = zd1;

    int          cyc = 0;
    int          acc_q[$];
    int          mv_q[$];
    logic [7:0]  md_q[$];
    int          n_clear = 0;
    int          clear_cyc = -1;
    int          ntests = 0;
    int          nfail = 0;

    always @(posedge clk) begin
        if (!reset && s_valid && s_ready) acc_q.push_back(cyc);
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset && m_valid) begin
            mv_q.push_back(cyc);
            md_q.push_back(m_data);
        end
        if (!reset && iir_clear) begin
            n_clear++;
            clear_cyc = cyc;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_ready"},    int'(s_ready), 1);
        chk({p, "_m_valid"},    int'(m_valid), 0);
        chk({p, "_m_data"},     int'(m_data), 0);
        chk({p, "_iir_x"},      int'(iir_x), 0);
        chk({p, "_iir_enable"}, int'(iir_enable), 0);
        chk({p, "_iir_clear"},  int'(iir_clear), 0);
        chk({p, "_cfg_busy"},   int'(cfg_busy), 0);
        chk({p, "_count"},      int'(sample_count), 0);
        chk({p, "_a0"},         int'($signed(iir_a0)), -8);
        chk({p, "_a1"},         int'($signed(iir_a1)), -8);
        chk({p, "_b0"},         int'($signed(iir_b0)), 8);
        chk({p, "_b1"},         int'($signed(iir_b1)), 16);
        chk({p, "_b2"},         int'($signed(iir_b2)), 8);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (cfg_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy_low"}, int'(cfg_busy), 0);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b1; s_valid = 1'b0; s_data = '0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tbl[i].din  = 8'(i + 1);
            tbl[i].dout = 8'(i + 1) ^ 8'hA5;
        end

        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back stream of 20 samples.
        acc_q.delete(); mv_q.delete(); md_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("s1_ready", int'(s_ready), 1);
            s_valid = 1'b1;
            s_data  = tbl[i].din;
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk("s1_mv_count", mv_q.size(), 20);
        for (int i = 0; i < 20 && i < mv_q.size() && i < acc_q.size(); i++) begin
            chk($sformatf("s1_data%0d", i), int'(md_q[i]), int'(tbl[i].dout));
            chk($sformatf("s1_lat%0d", i), mv_q[i] - acc_q[i], LAT + 1);
        end
        chk("s1_count", int'(sample_count), 20);
        chk("s1_idle_enable", int'(iir_enable), 0);
        chk("s1_x_hold", int'(iir_x), 20);

        // Commit with two samples in flight, new b1 written beforehand.
        acc_q.delete(); mv_q.delete(); md_q.delete(); n_clear = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h30;
        cfg_wr = 1'b1; cfg_addr = 3'd3; cfg_data = 8'd32;
        @(negedge clk);
        s_data = 8'h31; cfg_wr = 1'b0; cfg_commit = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; cfg_commit = 1'b0;
        chk("s2_busy_drain", int'(cfg_busy), 1);
        chk("s2_ready_drain", int'(s_ready), 0);
        chk("s2_b1_unchanged", int'($signed(iir_b1)), 16);
        chk("s2_count_drain", int'(sample_count), 22);
        wait_idle("s2");
        chk("s2_mv_count", mv_q.size(), 2);
        for (int i = 0; i < mv_q.size() && i < 2; i++) begin
            chk($sformatf("s2_data%0d", i), int'(md_q[i]), int'(8'(8'h30 + i) ^ 8'hA5));
        end
        chk("s2_clear_count", n_clear, 1);
        if (acc_q.size() == 2) chk("s2_clear_cycle", clear_cyc, acc_q[1] + LAT + 3);
        chk("s2_b1_new", int'($signed(iir_b1)), 32);
        chk("s2_count_zero", int'(sample_count), 0);
        chk("s2_ready_run", int'(s_ready), 1);

        // Write+commit same cycle, write during DRAIN, repeated commits while busy.
        n_clear = 0;
        @(negedge clk);
        c0 = cyc;
        cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd4; cfg_commit = 1'b1;
        @(negedge clk);
        chk("s3_busy_drain", int'(cfg_busy), 1);
        cfg_wr = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd3; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0; cfg_commit = 1'b1;
        @(negedge clk);
        chk("s3_busy_settle", int'(cfg_busy), 1);
        chk("s3_a0_settle", int'($signed(iir_a0)), 4);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        repeat (6) @(negedge clk);
        chk("s3_clear_count", n_clear, 1);
        chk("s3_clear_cycle", clear_cyc, c0 + 2);
        chk("s3_a0", int'($signed(iir_a0)), 4);
        chk("s3_b2", int'($signed(iir_b2)), 3);
        chk("s3_b1_kept", int'($signed(iir_b1)), 32);
        chk("s3_busy_low", int'(cfg_busy), 0);

        // Counter wrap at 2^CW-1.
        mv_q.delete(); md_q.delete();
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'(i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("s4_count_max", int'(sample_count), 31);
        s_valid = 1'b1; s_data = 8'h7F;
        @(negedge clk);
        s_valid = 1'b0;
        chk("s4_count_wrap", int'(sample_count), 0);
        repeat (LAT + 2) @(negedge clk);
        chk("s4_mv_count", mv_q.size(), 32);
        if (md_q.size() == 32) chk("s4_last_data", int'(md_q[31]), int'(8'h7F ^ 8'hA5));

        // Reset while draining abandons the commit and the in-flight result.
        mv_q.delete(); md_q.delete(); n_clear = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'h55; cfg_commit = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; cfg_commit = 1'b0;
        chk("s5_busy_drain", int'(cfg_busy), 1);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("s5");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("s5_no_mvalid", mv_q.size(), 0);
        chk("s5_no_clear", n_clear, 0);
        chk("s5_busy_after", int'(cfg_busy), 0);
        chk("s5_a0_default", int'($signed(iir_a0)), -8);
        chk("s5_b1_default", int'($signed(iir_b1)), 16);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
